// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch stage.
//   fetch_state_t    - fetch FSM state encoding (also exposed on state_dbg)
//   RESET_PC_DEFAULT - default first fetch address after reset
//   NOP_INSTR        - instruction word placed in IF/ID for a bubble
//   if_id_t          - 65-bit IF/ID pipeline register contents
package mips_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,   // request outstanding at pc_F
        S_HELD    = 2'd1,   // word parked in hold buffer, no request
        S_DISCARD = 2'd2    // request at req_addr outstanding, response is stale
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instr   = NOP_INSTR;
        b.pcplus4 = 32'h0000_0000;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, reset : clock, synchronous active-high reset (clears to a bubble)
//   en         : load enable; low freezes the register (decode stalled)
//   clr        : synchronous clear to a bubble, only effective when en=1
//   d, q       : register input / output contents
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    // A frozen register wins over bubble insertion: clr is ignored while en=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= if_id_bubble();
        end else if (en) begin
            if (clr) begin
                q <= if_id_bubble();
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns pc_F, drives the instruction-memory request and writes IF/ID.
//
// Build option: define FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot
// behaviour (the in-flight or buffered instruction after a taken branch is
// delivered, then fetch continues at the target). Without it, a redirect
// squashes that instruction.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   stall_F, stall_D      : hazard-unit stalls for PC and IF/ID
//   pcsrc_D, pcbranch_D   : branch taken / target, resolved in decode
//   imem_req, imem_addr   : instruction-memory request and address
//   imem_rvalid, imem_rdata : instruction-memory response
//   instr_D, pcplus4_D, valid_D : IF/ID outputs (valid_D=0 marks a bubble)
//   state_dbg             : current fetch FSM state
//
// Memory handshake: a request is open while imem_req=1. imem_addr is held
// constant for as long as the request is open. The request completes in the
// cycle imem_rvalid=1 (which may be its first cycle); imem_rdata is only
// meaningful in that cycle. imem_rvalid is ignored while imem_req=0.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_F,
    input  logic         stall_D,
    input  logic         pcsrc_D,
    input  logic [31:0]  pcbranch_D,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr_D,
    output logic [31:0]  pcplus4_D,
    output logic         valid_D,
    output fetch_state_t state_dbg
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    fetch_state_t state, state_next;
    logic [31:0]  pc_F, pc_next, pcplus4_F, deliver_pc;
    logic [31:0]  req_addr, hold_word;
    logic         hold_load, deliver, ifid_clr;
    logic         redirect, squash, hold;
    if_id_t       ifid_d, ifid_q;

    // A redirect presented while decode is stalled is ignored; decode
    // presents it again once it moves.
    assign redirect  = pcsrc_D & ~stall_D;
    // Squashing only happens without delay slots.
    assign squash    = redirect & ~DELAY_SLOT;
    // A word can only go into IF/ID when neither stage is stalled; otherwise
    // it is parked in the hold buffer.
    assign hold      = stall_F | stall_D;
    assign pcplus4_F = pc_F + 32'd4;

`ifdef FETCH_DELAY_SLOT_EN
    logic        redir_pending;
    logic [31:0] redir_target;

    // A redirect arriving in the same cycle as the delay-slot delivery
    // jumps straight to the new target.
    assign deliver_pc = redirect      ? pcbranch_D :
                        redir_pending ? redir_target : pcplus4_F;

    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pending <= 1'b0;
            redir_target  <= RESET_PC;
        end else if (deliver) begin
            redir_pending <= 1'b0;
        end else if (redirect) begin
            redir_pending <= 1'b1;
            redir_target  <= pcbranch_D;
        end
    end
`else
    assign deliver_pc = pcplus4_F;
`endif

    always_comb begin
        state_next     = state;
        pc_next        = pc_F;
        hold_load      = 1'b0;
        deliver        = 1'b0;
        // Any cycle that does not deliver writes a bubble (when IF/ID moves).
        ifid_clr       = 1'b1;
        ifid_d.instr   = imem_rdata;
        ifid_d.pcplus4 = pcplus4_F;
        ifid_d.valid   = 1'b1;

        case (state)
            S_FETCH: begin
                if (imem_rvalid) begin
                    if (squash) begin
                        pc_next = pcbranch_D;
                    end else if (hold) begin
                        hold_load  = 1'b1;
                        state_next = S_HELD;
                    end else begin
                        deliver = 1'b1;
                    end
                end else if (squash) begin
                    // The address must stay put until the old response
                    // arrives, so wait for it in DISCARD.
                    pc_next    = pcbranch_D;
                    state_next = S_DISCARD;
                end
            end
            S_HELD: begin
                ifid_d.instr = hold_word;
                if (squash) begin
                    pc_next    = pcbranch_D;
                    state_next = S_FETCH;
                end else if (!hold) begin
                    deliver    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (squash) begin
                    pc_next = pcbranch_D;
                end
                if (imem_rvalid) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (deliver) begin
            ifid_clr = 1'b0;
            pc_next  = deliver_pc;
        end
    end

    // req_addr follows pc_F throughout FETCH; pc_F cannot move while a
    // FETCH request is open, so this is the address of the open request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc_F      <= RESET_PC;
            req_addr  <= RESET_PC;
            hold_word <= NOP_INSTR;
        end else begin
            state <= state_next;
            pc_F  <= pc_next;
            if (state == S_FETCH) begin
                req_addr <= pc_F;
            end
            if (hold_load) begin
                hold_word <= imem_rdata;
            end
        end
    end

    assign imem_req  = ~reset & (state != S_HELD);
    assign imem_addr = (state == S_DISCARD) ? req_addr : pc_F;
    assign state_dbg = state;

    if_id_reg u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (~stall_D),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign instr_D   = ifid_q.instr;
    assign pcplus4_D = ifid_q.pcplus4;
    assign valid_D   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall_F = 1'b0;
    logic         stall_D = 1'b0;
    logic         pcsrc_D = 1'b0;
    logic [31:0]  pcbranch_D = 32'h0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr_D;
    logic [31:0]  pcplus4_D;
    logic         valid_D;
    fetch_state_t state_dbg;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .pcsrc_D     (pcsrc_D),
        .pcbranch_D  (pcbranch_D),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_D     (instr_D),
        .pcplus4_D   (pcplus4_D),
        .valid_D     (valid_D),
        .state_dbg   (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // ---------------- instruction memory model ----------------
    // mem_mode 0: zero-wait, 1: 3-cycle, 2: random 0..3 wait cycles
    int          mem_mode = 0;
    int          rand_lat = 0;
    int          first_lat;
    int          wait_left = 0;
    logic        busy = 1'b0;
    logic [31:0] busy_addr = 32'h0;

    always_comb first_lat = (mem_mode == 0) ? 0 : (mem_mode == 1) ? 2 : rand_lat;

    assign imem_rvalid = imem_req & (busy ? (wait_left == 0) : (first_lat == 0));
    assign imem_rdata  = imem_rvalid ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;   // abandoned request is forgotten
        end else if (imem_req) begin
            if (imem_rvalid) begin
                busy     <= 1'b0;
                rand_lat <= $urandom_range(0, 3);
            end else if (!busy) begin
                busy      <= 1'b1;
                wait_left <= first_lat - 1;
                busy_addr <= imem_addr;
            end else begin
                wait_left <= wait_left - 1;
            end
        end
    end

    // Protocol checks: no request in reset, address stable while open.
    always @(negedge clk) begin
        if (reset) begin
            check("req_in_reset", {31'b0, imem_req}, 32'h0);
        end else if (imem_req && busy) begin
            check("addr_stable", imem_addr, busy_addr);
        end
    end

    // ---------------- scoreboard ----------------
    // exp_q holds the program-order addresses still to be delivered to
    // decode. The head is the next instruction; once the queue drains the
    // program continues sequentially.
    logic [31:0] exp_q[$];
    logic [31:0] head_tmp;
    logic [31:0] e_tmp;
    logic        en_edge = 1'b0;

    initial forever begin
        @(posedge clk);
        en_edge = !reset && !stall_D;
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else if (pcsrc_D && !stall_D) begin
`ifdef FETCH_DELAY_SLOT_EN
            // the next sequential instruction is the delay slot
            head_tmp = exp_q[0];
            exp_q.delete();
            exp_q.push_back(head_tmp);
            exp_q.push_back(pcbranch_D);
`else
            exp_q.delete();
            exp_q.push_back(pcbranch_D);
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        if (en_edge && valid_D) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL deliver_unexpected: got pcplus4 %h expected none", pcplus4_D);
            end else begin
                e_tmp = exp_q.pop_front();
                check("instr_D", instr_D, mem_word(e_tmp));
                check("pcplus4_D", pcplus4_D, e_tmp + 32'd4);
                n_deliv++;
                if (exp_q.size() == 0) exp_q.push_back(e_tmp + 32'd4);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stall(input logic s);
        stall_F = s;
        stall_D = s;
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        pcsrc_D = 1'b0;
        set_stall(1'b0);
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) at +2 after an edge until imem_addr matches a.
    task automatic wait_addr(input logic [31:0] a, input int limit, input string name);
        int n;
        n = 0;
        #1;
        while (imem_addr !== a && n < limit) begin
            tick();
            #1;
            n++;
        end
        check(name, imem_addr, a);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (!valid_D && n < 20);
    endtask

    // ---------------- stimulus ----------------
    int   gap;
    logic saw;
    logic allow;

    initial begin
        // reset state and zero-wait streaming
        mem_mode = 0;
        do_reset(3);
        check("reset_valid_D", {31'b0, valid_D}, 32'h0);
        check("reset_instr_D", instr_D, 32'h0);
        check("reset_pcplus4_D", pcplus4_D, 32'h0);
        #1;
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("addr_0", imem_addr, RESET_PC);
        tick(); #1;
        check("addr_4", imem_addr, RESET_PC + 32'd4);
        check("first_valid", {31'b0, valid_D}, 32'h1);
        tick(); #1;
        check("addr_8", imem_addr, RESET_PC + 32'd8);

        // 3-cycle memory: one delivery every 3 cycles
        tick();
        mem_mode = 1;
        wait_valid(gap);
        check("wait_first_slow", {31'b0, valid_D}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            wait_valid(gap);
            check("slow_gap", gap, 3);
        end

        // stall both stages for 2 cycles while the word for 0x10 returns
        mem_mode = 0;
        tick();
        do_reset(2);
        wait_addr(32'h10, 20, "reach_0x10");
        set_stall(1'b1);
        tick(); #1;
        check("held_state", 32'(state_dbg), 32'(S_HELD));
        check("held_no_req", {31'b0, imem_req}, 32'h0);
        tick();
        set_stall(1'b0);
        tick(); #1;
        check("release_addr", imem_addr, 32'h14);
        check("release_instr", instr_D, mem_word(32'h10));
        tick(); #1;
        check("after_release_addr", imem_addr, 32'h18);

        // redirect to 0x100 while a slow request to 0x20 is open
        tick();
        mem_mode = 1;
        do_reset(2);
        wait_addr(32'h20, 100, "reach_0x20");
        pcsrc_D    = 1'b1;
        pcbranch_D = 32'h100;
        tick();
        pcsrc_D = 1'b0;
        #1;
`ifdef FETCH_DELAY_SLOT_EN
        check("redir_state", 32'(state_dbg), 32'(S_FETCH));
`else
        check("redir_state", 32'(state_dbg), 32'(S_DISCARD));
`endif
        check("redir_hold_addr", imem_addr, 32'h20);
        tick();
        wait_addr(32'h100, 10, "redir_next_addr");

        // redirect presented while decode is stalled is ignored
        tick();
        set_stall(1'b1);
        pcsrc_D    = 1'b1;
        pcbranch_D = 32'h200;
        repeat (2) tick();
        pcsrc_D = 1'b0;
        set_stall(1'b0);
        saw = 1'b0;
        repeat (15) begin
            tick(); #1;
            if (imem_req && imem_addr == 32'h200) saw = 1'b1;
        end
        check("stalled_redirect_ignored", {31'b0, saw}, 32'h0);

        // reset in the middle of an open request
        gap = 0;
        while (!(busy && imem_req) && gap < 10) begin
            tick();
            gap++;
        end
        check("found_open_req", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset_drops_req", {31'b0, imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_addr", imem_addr, RESET_PC);
        check("post_reset_req", {31'b0, imem_req}, 32'h1);
        check("post_reset_valid", {31'b0, valid_D}, 32'h0);

        // randomized traffic: stalls, redirects (incl. near address wrap), resets
        mem_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset   = 1'b1;
                pcsrc_D = 1'b0;
                set_stall(1'b0);
            end else begin
                set_stall($urandom_range(0, 9) < 2);
                allow   = stall_D || (exp_q.size() == 1);
                pcsrc_D = allow && ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 1) == 0)
                    pcbranch_D = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
                else
                    pcbranch_D = 32'($urandom_range(0, 255) << 2);
            end
        end
        reset   = 1'b0;
        pcsrc_D = 1'b0;
        set_stall(1'b0);
        repeat (10) tick();
        check("enough_deliveries", {31'b0, (n_deliv > 200)}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory request, and writes the IF/ID pipeline register consumed by decode. It applies the hazard unit's `stall_F`/`stall_D`, takes branch redirects resolved in decode, and tolerates a variable-latency instruction memory. It inserts bubbles while memory is slow and discards responses that belong to a squashed path.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high
- `stall_F`  in  1  hold PC (hazard unit)
- `stall_D`  in  1  hold IF/ID (hazard unit)
- `pcsrc_D`  in  1  branch taken, resolved in decode
- `pcbranch_D`  in  32  branch target
- `imem_req`  out  1  fetch request; held until response
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high
- `imem_rvalid`  in  1  response valid; may be high in the first request cycle
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `instr_D`  out  32  IF/ID instruction
- `pcplus4_D`  out  32  IF/ID PC+4
- `valid_D`  out  1  IF/ID holds a real instruction; 0 marks a bubble

## Operation
- Registers: `pc_F`, `req_addr`, IF/ID (`instr_D`, `pcplus4_D`, `valid_D`), 1-entry hold buffer, `redir_pending`/`redir_target` (delay-slot build only), FSM.
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=`pc_F`. `req_addr` latches `pc_F` when a request starts.
  - HELD: `imem_req`=0. A received instruction sits in the hold buffer.
  - DISCARD: `imem_req`=1, `imem_addr`=`req_addr`. Waiting to drop a stale response.
- Redirect occurs when `pcsrc_D` & !`stall_D`. A redirect while `stall_D`=1 is ignored; decode re-presents it.
- FETCH, `imem_rvalid`=1:
  - Redirect: drop the word, `pc_F`←`pcbranch_D`, IF/ID←bubble.
  - Else if `stall_F`: hold buffer←word, go HELD. IF/ID and `pc_F` are held.
  - Else: IF/ID←{word, `pc_F`+4, 1}, `pc_F`←`pc_F`+4.
- FETCH, `imem_rvalid`=0:
  - Redirect: `pc_F`←`pcbranch_D`, go DISCARD.
  - IF/ID←bubble when !`stall_D`.
- HELD:
  - When `stall_F`=0: IF/ID←buffer, `pc_F`←`pc_F`+4, go FETCH.
  - Redirect in HELD: drop the buffer, `pc_F`←`pcbranch_D`, IF/ID←bubble, go FETCH.
- DISCARD: on `imem_rvalid`, drop the data and go FETCH. IF/ID←bubble whenever !`stall_D`.
- Arithmetic: PC+4 is a 32-bit add and wraps 32'hFFFF_FFFC→0 silently. Low two PC bits are passed through unchecked.
- `stall_D`=1 always freezes IF/ID, which takes priority over bubble insertion.

## Timing
- Reset (synchronous):
  - `pc_F`=`RESET_PC`, state FETCH.
  - `instr_D`=0, `pcplus4_D`=0, `valid_D`=0, `redir_pending`=0.
  - `imem_req`=0 during any cycle with `reset`=1.
- Reset mid-request drops the outstanding response. Memory must tolerate abandoned requests.
- The first request is issued in the first cycle after `reset` falls.
- With zero-wait memory: fetch-to-IF/ID latency is 1 edge; throughput is 1 instr/cycle.
- With N-cycle memory: N−1 bubbles per instruction.
- A taken branch without delay slot costs 1 bubble with zero-wait memory.
- `imem_addr` must not change while `imem_req`=1 and `imem_rvalid`=0. DISCARD exists to guarantee this.

## Configuration
- Macro `FETCH_DELAY_SLOT_EN`.
- Defined (MIPS delay slot):
  - A redirect latches `redir_pending`/`redir_target`.
  - The in-flight or buffered instruction (the delay slot) is delivered normally.
  - `pc_F`←`redir_target` takes effect on that delivery, then `redir_pending` clears.
  - No DISCARD entry occurs.
- Undefined: squash behaviour as in Operation; the `redir_*` registers are absent.

## Structure
- Shared package `mips_pkg`: FSM state encoding, `RESET_PC` default, bubble/NOP encoding 32'h0000_0000.
- One sub-module `if_id_reg`: 65-bit register with `en` (=!`stall_D`) and synchronous `clr` (bubble).
- FSM and PC logic stay in `fetch_stage`.

## Test plan
- Reset, zero-wait memory returning `pc` as data: `imem_addr` reads 0, 4, 8 on consecutive cycles; `instr_D`/`pcplus4_D` = (0,4), (4,8), (8,12) one cycle later.
- 3-cycle memory: two `valid_D`=0 bubbles between instructions; `imem_addr` is constant for 3 cycles.
- `stall_F`=`stall_D`=1 for 2 cycles at PC 0x10 with `rvalid`: FSM goes HELD; the word is delivered on release; PC advances to 0x14 exactly once.
- Redirect to 0x100 while a 3-cycle request to 0x20 is outstanding (no macro): DISCARD holds `imem_addr`=0x20 until `rvalid`, the 0x20 word never appears in IF/ID, the next request is 0x100.
- Same as previous with `FETCH_DELAY_SLOT_EN`: the 0x20 word reaches IF/ID with `valid_D`=1, then the next fetch is 0x100.
- Redirect with `stall_D`=1: ignored, `pc_F` unchanged. Reset asserted mid-wait: next request is `RESET_PC`, `valid_D`=0.
